id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline stage feeding the ALU. Decodes the MIPS instruction into the 4-bit ALU op and
//  selects/forwards operands (v1, v2). Registers them, together with dest/write-enable/load
//  flags, for one cycle.
//  Generates the load-use interlock, stall hold and flush bubble for the EX stage.
// PARAMETERS
//  (none) -- widths fixed: XLEN=32, REGW=5, ALU op 4 bits (constants in mips_pkg)
// PORTS
//  clk            in   1   clock, rising edge
//  resetn         in   1   asynchronous active-low reset
//  stall          in   1   downstream stall: hold all output registers
//  flush          in   1   squash: load bubble next edge
//  in_valid       in   1   in_instr/in_rs_val/in_rt_val are valid
//  in_instr       in   32  instruction from ID
//  in_rs_val      in   32  register-file value of rs
//  in_rt_val      in   32  register-file value of rt
//  fwd_mem_wen    in   1   EX/MEM stage writes fwd_mem_reg
//  fwd_mem_reg    in   5   EX/MEM destination
//  fwd_mem_val    in   32  EX/MEM result
//  fwd_wb_wen     in   1   MEM/WB stage writes fwd_wb_reg
//  fwd_wb_reg     in   5   MEM/WB destination
//  fwd_wb_val     in   32  MEM/WB result
//  hazard_stall   out  1   combinational: upstream must hold in_instr this cycle
//  ex_valid       out  1   registered: EX slot holds a real instruction
//  ex_op          out  4   registered ALU op
//  ex_v1, ex_v2   out  32  registered ALU operands
//  ex_dst         out  5   registered destination register
//  ex_wen         out  1   registered regfile write enable (0 whenever ex_valid=0)
//  ex_is_load     out  1   registered: lw; ALU result is address
//  ex_is_store    out  1   registered: sw; ex_store_val holds data
//  ex_store_val   out  32  registered forwarded rt value for sw
//  ex_illegal     out  1   registered: unsupported opcode/funct (ex_wen forced 0)
// BEHAVIOUR
//  Reset: every ex_* output 0; hazard_stall follows its inputs (0 when ex_valid=0 and in_valid=0).
//  Latency 1: fields decoded from cycle-N inputs appear on ex_* after edge N+1.
//  Priority per edge: flush > stall > hazard_stall > load.
//   - flush: ex_valid/ex_wen/ex_is_load/ex_is_store/ex_illegal <= 0; data fields are don't-care.
//   - stall: all ex_* hold.
//   - hazard_stall: load bubble (as flush).
//   - otherwise: load decode of the inputs, ex_valid <= in_valid.
//  R-type (opcode 0), funct f:
//   - shifts, f[5:3]=000: op={2'b00,f[1:0]}; v1 = f[2] ? {27'b0, rs[4:0]} : {27'b0, shamt}; v2=rt.
//   - f[5:3]=100: op = {f[3:1],f[0]&f[2]} ^ 4'b1100, so addu/subu map to add/sub.
//   - slt 101010: op 0110.
//   - dst=rd; wen=(rd!=0).
//   - other funct, incl. sltu: illegal.
//  I-type, v1=rs, v2=imm, dst=rt:
//   - addi/addiu: op 1100, v2 = sign-ext imm.
//   - slti: op 0110, v2 = sign-ext imm.
//   - andi/ori/xori: ops 1000/1001/1010, v2 = zero-ext imm.
//   - lui: op 1111, v2={imm,16'b0}.
//   - lw: op 1100, v2 = sign-ext imm, is_load.
//   - sw: op 1100, v2 = sign-ext imm, is_store, wen=0.
//   - any other opcode: illegal, wen=0.
//  Operand source per rs/rt (reg 0 always reads 0, never forwarded; see CONFIGURATION).
//  Load-use: hazard_stall=1 when in_valid & ex_valid & ex_is_load & ex_dst!=0 & ex_dst matches a
//   source register actually used (rs always except shifts with f[2]=0; rt for R-type and sw).
//  hazard_stall is ignored while flush=1; it is still raised during stall but has no effect then.
//  Reset mid-stream: asynchronous clear; the first post-reset edge loads normally.
// CONFIGURATION
//  ID_EX_FORWARD_EN defined:
//   - operand = fwd_mem_val if fwd_mem_wen & fwd_mem_reg==src; else fwd_wb_val on the same rule
//     for the WB stage; else in_*_val. EX/MEM beats MEM/WB.
//  ID_EX_FORWARD_EN undefined:
//   - fwd_*_val ignored; operands always in_*_val.
//   - hazard_stall additionally raised on any used-source match with
//     (ex_valid & ex_wen & ex_dst), (fwd_mem_wen & fwd_mem_reg) or (fwd_wb_wen & fwd_wb_reg).
// STRUCTURE
//  mips_pkg: alu_op_t enum (SLL..PASS2), opcode/funct localparams, decode_t struct
//   {op, use_rs, use_rt, sel_imm, dst, wen, is_load, is_store, illegal}.
//  Sub-module id_ex_decode (combinational instr -> decode_t). This module holds forwarding,
//   interlock and registers.
// TESTING
//  - add $3,$1,$2 (rs=5, rt=7, no fwd) -> next edge: ex_op=1100, v1=5, v2=7, dst=3, wen=1.
//  - sll $4,$2,3 then sllv $4,$2,$1 with $1=0x23 -> v1=3, then v1=0x03 (rs[4:0]); op 0000.
//  - lw $5,4($1) followed by addu $6,$5,$5 -> hazard_stall=1 one cycle, bubble (ex_valid=0),
//    then addu issues with v1/v2 = fwd_mem_val.
//  - fwd_mem and fwd_wb both target $2 (vals 0xA / 0xB) -> v2=0xA; target $0 -> v2=0.
//  - stall=1 and flush=1 on the same edge -> ex_valid=0. stall alone for 3 cycles -> ex_* unchanged.
//  - opcode 0x3F, or sltu -> ex_illegal=1, ex_wen=0. resetn low mid-stream -> all ex_* 0 at once.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the ID->EX stage: ALU op encoding,
// MIPS opcode/funct values and the decoded-instruction record.
package mips_pkg;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [3:0] {
        ALU_SLL   = 4'h0,
        ALU_SH1   = 4'h1,
        ALU_SRL   = 4'h2,
        ALU_SRA   = 4'h3,
        ALU_SLT   = 4'h6,
        ALU_AND   = 4'h8,
        ALU_OR    = 4'h9,
        ALU_XOR   = 4'hA,
        ALU_NOR   = 4'hB,
        ALU_ADD   = 4'hC,
        ALU_SUB   = 4'hE,
        ALU_PASS2 = 4'hF
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Operand shaping: REG keeps v1=rs/v2=rt, SHAMT/SHRS replace v1 for
    // shifts, the rest replace v2 with an immediate form.
    typedef enum logic [2:0] {
        SEL_REG, SEL_SHAMT, SEL_SHRS, SEL_SEXT, SEL_ZEXT, SEL_UPPER
    } sel_t;

    typedef struct packed {
        alu_op_t          op;
        logic             use_rs;
        logic             use_rt;
        sel_t             sel_imm;
        logic [REGW-1:0]  dst;
        logic             wen;
        logic             is_load;
        logic             is_store;
        logic             illegal;
    } decode_t;

    // True when a producer with enable en writes register src.
    function automatic logic reg_hit(logic en, logic [REGW-1:0] dst, logic [REGW-1:0] src);
        return en && (dst == src);
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// Upstream/forwarding inputs and registered EX-slot outputs of id_ex_stage.
// master = ID side driving the stage, slave = the stage itself.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic              stall, flush, in_valid;
    logic [XLEN-1:0]   in_instr, in_rs_val, in_rt_val;
    logic              fwd_mem_wen, fwd_wb_wen;
    logic [REGW-1:0]   fwd_mem_reg, fwd_wb_reg;
    logic [XLEN-1:0]   fwd_mem_val, fwd_wb_val;
    logic              hazard_stall;
    logic              ex_valid, ex_wen, ex_is_load, ex_is_store, ex_illegal;
    alu_op_t           ex_op;
    logic [XLEN-1:0]   ex_v1, ex_v2, ex_store_val;
    logic [REGW-1:0]   ex_dst;

    modport master (
        output stall, flush, in_valid, in_instr, in_rs_val, in_rt_val,
               fwd_mem_wen, fwd_mem_reg, fwd_mem_val, fwd_wb_wen, fwd_wb_reg, fwd_wb_val,
        input  hazard_stall, ex_valid, ex_op, ex_v1, ex_v2, ex_dst, ex_wen,
               ex_is_load, ex_is_store, ex_store_val, ex_illegal
    );
    modport slave (
        input  stall, flush, in_valid, in_instr, in_rs_val, in_rt_val,
               fwd_mem_wen, fwd_mem_reg, fwd_mem_val, fwd_wb_wen, fwd_wb_reg, fwd_wb_val,
        output hazard_stall, ex_valid, ex_op, ex_v1, ex_v2, ex_dst, ex_wen,
               ex_is_load, ex_is_store, ex_store_val, ex_illegal
    );
endinterface

// File: rtl/id_ex_decode.sv
// Combinational MIPS instruction decode into a decode_t record.
import mips_pkg::*;

module id_ex_decode (
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    output decode_t         dec
);
    // Classify the instruction, pick ALU op, operand shaping and destination.
    always_comb begin
        dec        = '0;
        dec.use_rs = 1'b1;
        if (opcode == OP_RTYPE) begin
            dec.use_rt = 1'b1;
            dec.dst    = rd;
            if (funct[5:3] == 3'b000) begin
                // shamt shifts never read rs; variable shifts take rs[4:0]
                dec.op      = alu_op_t'({2'b00, funct[1:0]});
                dec.sel_imm = funct[2] ? SEL_SHRS : SEL_SHAMT;
                dec.use_rs  = funct[2];
            end else if (funct[5:3] == 3'b100) begin
                // folds the unsigned add/sub variants onto add/sub
                dec.op = alu_op_t'({funct[3:1], funct[0] & funct[2]} ^ 4'b1100);
            end else if (funct == FN_SLT) begin
                dec.op = ALU_SLT;
            end else begin
                dec.illegal = 1'b1;
            end
            dec.wen = !dec.illegal && (rd != '0);
        end else begin
            dec.dst     = rt;
            dec.op      = ALU_ADD;
            dec.sel_imm = SEL_SEXT;
            case (opcode)
                OP_ADDI, OP_ADDIU: ;
                OP_SLTI: dec.op = ALU_SLT;
                OP_ANDI: begin dec.op = ALU_AND;   dec.sel_imm = SEL_ZEXT;  end
                OP_ORI:  begin dec.op = ALU_OR;    dec.sel_imm = SEL_ZEXT;  end
                OP_XORI: begin dec.op = ALU_XOR;   dec.sel_imm = SEL_ZEXT;  end
                OP_LUI:  begin dec.op = ALU_PASS2; dec.sel_imm = SEL_UPPER; end
                OP_LW:   dec.is_load = 1'b1;
                OP_SW:   begin dec.is_store = 1'b1; dec.use_rt = 1'b1; end
                default: dec.illegal = 1'b1;
            endcase
            dec.wen = !dec.illegal && !dec.is_store && (rt != '0);
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand select/forward, load-use interlock,
// stall hold and flush bubble.
// Optional feature: define ID_EX_FORWARD_EN to forward EX/MEM and MEM/WB
// results into the operands; without it, any pending writer of a source
// register raises hazard_stall instead.
import mips_pkg::*;

module id_ex_stage (
    input  logic          clk,
    input  logic          resetn,
    id_ex_stage_if.slave  bus
);
    logic [REGW-1:0] rs, rt, shamt;
    logic [15:0]     imm;
    decode_t         dec;
    logic [XLEN-1:0] rs_val, rt_val, v1, v2;
    logic            raw_rs, raw_rt, hit_rs, hit_rt;

    assign rs    = bus.in_instr[25:21];
    assign rt    = bus.in_instr[20:16];
    assign shamt = bus.in_instr[10:6];
    assign imm   = bus.in_instr[15:0];

    id_ex_decode u_dec (
        .opcode (bus.in_instr[31:26]),
        .funct  (bus.in_instr[5:0]),
        .rt     (rt),
        .rd     (bus.in_instr[15:11]),
        .dec    (dec)
    );

    // Source values: forwarded (EX/MEM over MEM/WB) when enabled; $0 is always zero.
    always_comb begin
        rs_val = bus.in_rs_val;
        rt_val = bus.in_rt_val;
`ifdef ID_EX_FORWARD_EN
        if (reg_hit(bus.fwd_wb_wen,  bus.fwd_wb_reg,  rs)) rs_val = bus.fwd_wb_val;
        if (reg_hit(bus.fwd_mem_wen, bus.fwd_mem_reg, rs)) rs_val = bus.fwd_mem_val;
        if (reg_hit(bus.fwd_wb_wen,  bus.fwd_wb_reg,  rt)) rt_val = bus.fwd_wb_val;
        if (reg_hit(bus.fwd_mem_wen, bus.fwd_mem_reg, rt)) rt_val = bus.fwd_mem_val;
`endif
        if (rs == '0) rs_val = '0;
        if (rt == '0) rt_val = '0;
    end

    // Shape the ALU operands from the decoded selector.
    always_comb begin
        v1 = rs_val;
        v2 = rt_val;
        case (dec.sel_imm)
            SEL_SHAMT: v1 = {{(XLEN-REGW){1'b0}}, shamt};
            SEL_SHRS:  v1 = {{(XLEN-REGW){1'b0}}, rs_val[REGW-1:0]};
            SEL_SEXT:  v2 = {{16{imm[15]}}, imm};
            SEL_ZEXT:  v2 = {16'b0, imm};
            SEL_UPPER: v2 = {imm, 16'b0};
            default: ;
        endcase
    end

`ifdef ID_EX_FORWARD_EN
    assign raw_rs = 1'b0;
    assign raw_rt = 1'b0;
`else
    // Without forwarding every in-flight writer of a source must drain first.
    assign raw_rs = reg_hit(bus.ex_valid && bus.ex_wen, bus.ex_dst, rs)
                 || reg_hit(bus.fwd_mem_wen, bus.fwd_mem_reg, rs)
                 || reg_hit(bus.fwd_wb_wen,  bus.fwd_wb_reg,  rs);
    assign raw_rt = reg_hit(bus.ex_valid && bus.ex_wen, bus.ex_dst, rt)
                 || reg_hit(bus.fwd_mem_wen, bus.fwd_mem_reg, rt)
                 || reg_hit(bus.fwd_wb_wen,  bus.fwd_wb_reg,  rt);
`endif

    assign hit_rs = dec.use_rs && (rs != '0)
                 && (reg_hit(bus.ex_valid && bus.ex_is_load, bus.ex_dst, rs) || raw_rs);
    assign hit_rt = dec.use_rt && (rt != '0)
                 && (reg_hit(bus.ex_valid && bus.ex_is_load, bus.ex_dst, rt) || raw_rt);
    assign bus.hazard_stall = bus.in_valid && (hit_rs || hit_rt);

    // EX slot register: flush > stall > interlock bubble > load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_op        <= ALU_SLL;
            bus.ex_v1        <= '0;
            bus.ex_v2        <= '0;
            bus.ex_dst       <= '0;
            bus.ex_wen       <= 1'b0;
            bus.ex_is_load   <= 1'b0;
            bus.ex_is_store  <= 1'b0;
            bus.ex_store_val <= '0;
            bus.ex_illegal   <= 1'b0;
        end else if (bus.flush || (!bus.stall && bus.hazard_stall)) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_wen      <= 1'b0;
            bus.ex_is_load  <= 1'b0;
            bus.ex_is_store <= 1'b0;
            bus.ex_illegal  <= 1'b0;
        end else if (!bus.stall) begin
            bus.ex_valid     <= bus.in_valid;
            bus.ex_op        <= dec.op;
            bus.ex_v1        <= v1;
            bus.ex_v2        <= v2;
            bus.ex_dst       <= dec.dst;
            bus.ex_wen       <= bus.in_valid && dec.wen;
            bus.ex_is_load   <= bus.in_valid && dec.is_load;
            bus.ex_is_store  <= bus.in_valid && dec.is_store;
            bus.ex_store_val <= rt_val;
            bus.ex_illegal   <= bus.in_valid && dec.illegal;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: an independent table-driven model
// predicts the EX slot each cycle; predictions are queued at drive time
// and compared after the edge.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus();
    id_ex_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] v1, v2;
        logic [4:0]  dst;
        logic        wen, ld, st;
        logic [31:0] sval;
        logic        ill;
    } ex_t;

    ex_t  m;
    ex_t  sb[$];
    int   n_run = 0;
    int   n_fail = 0;
    logic last_hz;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, logic [5:0] fn);
        logic [31:0] w;
        w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
        return w;
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] opc, int rs, int rt, logic [15:0] imm);
        logic [31:0] w;
        w = {opc, 5'(rs), 5'(rt), imm};
        return w;
    endfunction

    function automatic logic [31:0] src_val(logic [4:0] r, logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
`ifdef ID_EX_FORWARD_EN
        if (bus.fwd_mem_wen && bus.fwd_mem_reg == r) return bus.fwd_mem_val;
        if (bus.fwd_wb_wen && bus.fwd_wb_reg == r) return bus.fwd_wb_val;
`endif
        return rf;
    endfunction

    function automatic logic hit(logic [4:0] s);
        logic h;
        h = m.valid && m.ld && m.dst == s;
`ifndef ID_EX_FORWARD_EN
        h = h || (m.valid && m.wen && m.dst == s)
              || (bus.fwd_mem_wen && bus.fwd_mem_reg == s)
              || (bus.fwd_wb_wen && bus.fwd_wb_reg == s);
`endif
        return (s != 5'd0) && h;
    endfunction

    task automatic predict(output ex_t e, output logic hz);
        logic [31:0] ins, rsv, rtv, sx;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  opc, fn;
        logic        urs, urt, legal;
        ins = bus.in_instr;
        opc = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
        sx  = {{16{ins[15]}}, ins[15:0]};
        rsv = src_val(rs, bus.in_rs_val);
        rtv = src_val(rt, bus.in_rt_val);
        e = '0; urs = 1'b1; urt = 1'b0; legal = 1'b1;
        e.v1 = rsv; e.sval = rtv;
        if (opc == 6'h00) begin
            urt = 1'b1; e.dst = rd; e.v2 = rtv;
            case (fn)
                6'h00: begin e.op = 4'h0; e.v1 = {27'd0, sh}; urs = 1'b0; end
                6'h01: begin e.op = 4'h1; e.v1 = {27'd0, sh}; urs = 1'b0; end
                6'h02: begin e.op = 4'h2; e.v1 = {27'd0, sh}; urs = 1'b0; end
                6'h03: begin e.op = 4'h3; e.v1 = {27'd0, sh}; urs = 1'b0; end
                6'h04: begin e.op = 4'h0; e.v1 = {27'd0, rsv[4:0]}; end
                6'h05: begin e.op = 4'h1; e.v1 = {27'd0, rsv[4:0]}; end
                6'h06: begin e.op = 4'h2; e.v1 = {27'd0, rsv[4:0]}; end
                6'h07: begin e.op = 4'h3; e.v1 = {27'd0, rsv[4:0]}; end
                6'h20, 6'h21: e.op = 4'hC;
                6'h22, 6'h23: e.op = 4'hE;
                6'h24: e.op = 4'h8;
                6'h25: e.op = 4'h9;
                6'h26: e.op = 4'hA;
                6'h27: e.op = 4'hB;
                6'h2A: e.op = 4'h6;
                default: legal = 1'b0;
            endcase
            e.wen = legal && rd != 5'd0;
        end else begin
            e.dst = rt; e.op = 4'hC; e.v2 = sx;
            case (opc)
                6'h08, 6'h09: ;
                6'h0A: e.op = 4'h6;
                6'h0C: begin e.op = 4'h8; e.v2 = {16'd0, ins[15:0]}; end
                6'h0D: begin e.op = 4'h9; e.v2 = {16'd0, ins[15:0]}; end
                6'h0E: begin e.op = 4'hA; e.v2 = {16'd0, ins[15:0]}; end
                6'h0F: begin e.op = 4'hF; e.v2 = {ins[15:0], 16'd0}; end
                6'h23: e.ld = 1'b1;
                6'h2B: begin e.st = 1'b1; urt = 1'b1; end
                default: legal = 1'b0;
            endcase
            e.wen = legal && !e.st && rt != 5'd0;
        end
        e.valid = bus.in_valid;
        e.ill   = bus.in_valid && !legal;
        e.wen   = bus.in_valid && e.wen;
        e.ld    = bus.in_valid && e.ld;
        e.st    = bus.in_valid && e.st;
        hz = bus.in_valid && ((urs && hit(rs)) || (urt && hit(rt)));
    endtask

    task automatic compare(ex_t x);
        check("ctl", 32'({bus.ex_valid, bus.ex_wen, bus.ex_is_load, bus.ex_is_store, bus.ex_illegal}),
              32'({x.valid, x.wen, x.ld, x.st, x.ill}));
        if (x.valid && !x.ill) begin
            check("op",  32'(bus.ex_op), 32'(x.op));
            check("v1",  bus.ex_v1, x.v1);
            check("v2",  bus.ex_v2, x.v2);
            check("dst", 32'(bus.ex_dst), 32'(x.dst));
            if (x.st) check("sval", bus.ex_store_val, x.sval);
        end
    endtask

    // One clock: predict, queue, clock, pop and compare.
    task automatic tick();
        ex_t e, nx;
        logic hz;
        #1;
        predict(e, hz);
        last_hz = hz;
        check("hazard", 32'(bus.hazard_stall), 32'(hz));
        nx = m;
        if (bus.flush || (!bus.stall && hz)) begin
            nx.valid = 1'b0; nx.wen = 1'b0; nx.ld = 1'b0; nx.st = 1'b0; nx.ill = 1'b0;
        end else if (!bus.stall) begin
            nx = e;
        end
        sb.push_back(nx);
        @(posedge clk);
        #1;
        nx = sb.pop_front();
        m = nx;
        compare(nx);
    endtask

    task automatic clr();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        bus.in_instr = '0; bus.in_rs_val = '0; bus.in_rt_val = '0;
        bus.fwd_mem_wen = 1'b0; bus.fwd_mem_reg = '0; bus.fwd_mem_val = '0;
        bus.fwd_wb_wen = 1'b0; bus.fwd_wb_reg = '0; bus.fwd_wb_val = '0;
    endtask

    task automatic drive(logic [31:0] ins, logic [31:0] rsv, logic [31:0] rtv);
        bus.in_valid = 1'b1; bus.in_instr = ins;
        bus.in_rs_val = rsv; bus.in_rt_val = rtv;
    endtask

    task automatic check_all_zero(string tag);
        check(tag, 32'({bus.ex_valid, bus.ex_wen, bus.ex_is_load, bus.ex_is_store,
                        bus.ex_illegal, bus.ex_op, bus.ex_dst}), 32'd0);
        check({tag, "_v"}, bus.ex_v1 | bus.ex_v2 | bus.ex_store_val, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rfn [12];
        logic [5:0] iop [10];
        rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h21, 6'h22, 6'h24, 6'h27, 6'h2A, 6'h2B, 6'h3F};
        iop = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        m = '0;
        last_hz = 1'b0;
        clr();
        #3;
        check_all_zero("rst");
        check("rst_hazard", 32'(bus.hazard_stall), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // add $3,$1,$2
        drive(r_ins(1, 2, 3, 0, 6'h20), 32'd5, 32'd7); tick();
        check("add_op", 32'(bus.ex_op), 32'hC);
        check("add_v1v2", {bus.ex_v1[15:0], bus.ex_v2[15:0]}, 32'h0005_0007);
        // sll $4,$2,3 then sllv $4,$2,$1 with $1=0x23
        drive(r_ins(0, 2, 4, 3, 6'h00), 32'd9, 32'h11); tick();
        check("sll_v1", bus.ex_v1, 32'd3);
        drive(r_ins(1, 2, 4, 0, 6'h04), 32'h23, 32'h11); tick();
        check("sllv_v1", bus.ex_v1, 32'd3);

        // lw $5,4($1) then addu $6,$5,$5: held until the interlock releases
        drive(i_ins(6'h23, 1, 5, 16'd4), 32'h100, 32'd0); tick();
        drive(r_ins(5, 5, 6, 0, 6'h21), 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            bus.fwd_mem_wen = (k == 1); bus.fwd_mem_reg = 5'd5; bus.fwd_mem_val = 32'hDEAD;
            bus.fwd_wb_wen  = (k == 2); bus.fwd_wb_reg  = 5'd5; bus.fwd_wb_val  = 32'hDEAD;
            if (k == 3) begin bus.in_rs_val = 32'hDEAD; bus.in_rt_val = 32'hDEAD; end
            tick();
            if (k == 0) check("lu_bubble", 32'(bus.ex_valid), 32'd0);
            if (!last_hz) break;
        end
        check("lu_issue", 32'(bus.ex_valid), 32'd1);
        check("lu_v1", bus.ex_v1, 32'hDEAD);

        // both forward stages target $2, then both target $0
        clr();
        drive(r_ins(3, 2, 8, 0, 6'h20), 32'd1, 32'h99);
        bus.fwd_mem_wen = 1'b1; bus.fwd_mem_reg = 5'd2; bus.fwd_mem_val = 32'hA;
        bus.fwd_wb_wen  = 1'b1; bus.fwd_wb_reg  = 5'd2; bus.fwd_wb_val  = 32'hB;
        tick();
        bus.fwd_mem_reg = 5'd0; bus.fwd_wb_reg = 5'd0;
        drive(r_ins(3, 0, 8, 0, 6'h20), 32'd1, 32'h55); tick();
        check("zero_v2", bus.ex_v2, 32'd0);

        // ori then 3 stalled cycles with changing inputs
        clr();
        drive(i_ins(6'h0D, 1, 9, 16'hF0F0), 32'd1, 32'd0); tick();
        for (int k = 0; k < 3; k++) begin
            bus.stall = 1'b1;
            drive(r_ins(k + 1, 2, 10, 0, 6'h22), 32'(k * 3), 32'h7);
            tick();
            check("stall_v2", bus.ex_v2, 32'h0000_F0F0);
        end
        bus.flush = 1'b1; tick();
        check("stall_flush", 32'(bus.ex_valid), 32'd0);

        // illegal opcode, sltu, in_valid low
        clr();
        drive({6'h3F, 26'h0}, 32'd0, 32'd0); tick();
        check("ill_opc", 32'({bus.ex_illegal, bus.ex_wen}), 32'b10);
        drive(r_ins(1, 2, 3, 0, 6'h2B), 32'd0, 32'd0); tick();
        check("ill_sltu", 32'({bus.ex_illegal, bus.ex_wen}), 32'b10);
        drive(r_ins(1, 2, 3, 0, 6'h20), 32'd0, 32'd0); bus.in_valid = 1'b0; tick();

        // immediate forms and store
        drive(i_ins(6'h0F, 0, 7, 16'h1234), 32'd0, 32'd0); tick();
        check("lui_v2", bus.ex_v2, 32'h1234_0000);
        drive(i_ins(6'h0A, 3, 4, 16'hFFFF), 32'd9, 32'd0); tick();
        drive(i_ins(6'h0E, 3, 7, 16'h8001), 32'd9, 32'd0); tick();
        drive(i_ins(6'h2B, 1, 2, 16'hFFF8), 32'h1000, 32'hCAFE); tick();
        check("sw_v2", bus.ex_v2, 32'hFFFF_FFF8);
        check("sw_sval", bus.ex_store_val, 32'hCAFE);

        // random traffic on a small register set to provoke hazards
        for (int n = 0; n < 300; n++) begin
            logic [15:0] imm;
            imm = 16'($urandom);
            if ($urandom_range(0, 1) == 0)
                bus.in_instr = r_ins($urandom_range(0, 3), $urandom_range(0, 3),
                                     $urandom_range(0, 3), $urandom_range(0, 31),
                                     rfn[$urandom_range(0, 11)]);
            else
                bus.in_instr = i_ins(iop[$urandom_range(0, 9)], $urandom_range(0, 3),
                                     $urandom_range(0, 3), imm);
            bus.in_valid    = ($urandom_range(0, 7) != 0);
            bus.in_rs_val   = $urandom; bus.in_rt_val = $urandom;
            bus.stall       = ($urandom_range(0, 7) == 0);
            bus.flush       = ($urandom_range(0, 15) == 0);
            bus.fwd_mem_wen = $urandom_range(0, 1) == 1; bus.fwd_mem_reg = 5'($urandom_range(0, 3));
            bus.fwd_mem_val = $urandom;
            bus.fwd_wb_wen  = $urandom_range(0, 1) == 1; bus.fwd_wb_reg = 5'($urandom_range(0, 3));
            bus.fwd_wb_val  = $urandom;
            tick();
        end

        // asynchronous reset in the middle of a cycle
        clr();
        drive(i_ins(6'h23, 1, 5, 16'd8), 32'h40, 32'd0); tick();
        #2 resetn = 1'b0;
        #1 check_all_zero("async_rst");
        m = '0;
        #2 resetn = 1'b1;
        drive(r_ins(1, 2, 3, 0, 6'h20), 32'd5, 32'd7); tick();
        check("post_rst_valid", 32'(bus.ex_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
